// File: rtl/bram_capture_writer_if.sv
// Bundle of the control, sample and BRAM port-B signals of the capture writer.
// The writer itself takes the slave view; whatever drives arm/trig/samples
// and watches the BRAM port takes the master view.
interface bram_capture_writer_if #(
    parameter int ADR_W = 11,
    parameter int DAT_W = 8
);
    logic             arm;
    logic             abort;
    logic             trig;
    logic [ADR_W-1:0] depth;
    logic             smp_valid;
    logic [DAT_W-1:0] smp_data;
    logic [ADR_W-1:0] bram_adr;
    logic [DAT_W-1:0] bram_din;
    logic             bram_en;
    logic             bram_we;
    logic             busy;
    logic             done;
    logic [ADR_W:0]   count;

    modport master (
        output arm, abort, trig, depth, smp_valid, smp_data,
        input  bram_adr, bram_din, bram_en, bram_we, busy, done, count
    );

    modport slave (
        input  arm, abort, trig, depth, smp_valid, smp_data,
        output bram_adr, bram_din, bram_en, bram_we, busy, done, count
    );
endinterface

// File: rtl/bram_capture_writer.sv
// Capture writer: after an arm pulse and a fresh rising edge on trig, writes
// up to `limit` valid samples into BRAM port B at consecutive addresses from 0.
// Every accepted sample becomes a registered one-cycle write on the next clock.
module bram_capture_writer #(
    parameter int ADR_W = 11,
    parameter int DAT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_capture_writer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             trig_q, trig_d;
    logic [ADR_W:0]   limit_q, limit_d;
    logic [ADR_W:0]   count_q, count_d;
    logic [ADR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADR_W-1:0] bram_adr_q, bram_adr_d;
    logic [DAT_W-1:0] bram_din_q, bram_din_d;
    logic             bram_en_q, bram_en_d;
    logic             bram_we_q, bram_we_d;
    logic             done_q, done_d;

    logic trig_rise;
    logic full;
    logic accept;

    // A trig already high when armed has trig_q high too, so it never counts as an edge.
    assign trig_rise = bus.trig & ~trig_q;
    // count reaching the limit blocks the sample that arrives alongside the last write.
    assign full      = (count_q == limit_q);
    assign accept    = (state_q == ST_CAPTURE) && bus.smp_valid && !full && !bus.abort;

    // Next-state, capture bookkeeping and write-port staging.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        trig_d     = bus.trig;
        limit_d    = limit_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        bram_adr_d = bram_adr_q;
        bram_din_d = bram_din_q;
        bram_en_d  = 1'b0;
        bram_we_d  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.arm) begin
                    state_d  = ST_ARMED;
                    count_d  = '0;
                    wr_ptr_d = '0;
                    // depth 0 stands for a full 2^ADR_W-sample buffer.
                    limit_d  = (bus.depth == '0) ? {1'b1, {ADR_W{1'b0}}}
                                                 : {1'b0, bus.depth};
                end
            end
            ST_ARMED: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (trig_rise) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (full) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The pointer wraps naturally at 2^ADR_W; that only matters when depth is 0.
        if (accept) begin
            bram_en_d  = 1'b1;
            bram_we_d  = 1'b1;
            bram_adr_d = wr_ptr_q;
            bram_din_d = bus.smp_data;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            count_d    = count_q + 1'b1;
        end

        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q    <= ST_IDLE;
            trig_q     <= 1'b0;
            limit_q    <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            bram_adr_q <= '0;
            bram_din_q <= '0;
            bram_en_q  <= 1'b0;
            bram_we_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trig_d;
            limit_q    <= limit_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            bram_adr_q <= bram_adr_d;
            bram_din_q <= bram_din_d;
            bram_en_q  <= bram_en_d;
            bram_we_q  <= bram_we_d;
            done_q     <= done_d;
        end
    end

    assign bus.bram_adr = bram_adr_q;
    assign bus.bram_din = bram_din_q;
    assign bus.bram_en  = bram_en_q;
    assign bus.bram_we  = bram_we_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.busy     = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);

endmodule

// File: tb/tb_bram_capture_writer.sv
// Directed bench for bram_capture_writer: a table of per-cycle input/expected
// records covering normal capture, trigger qualification, abort, arm/abort
// priority and reset, plus a hand-written full-depth (depth=0) capture.
module tb_bram_capture_writer;

    localparam int ADR_W = 11;
    localparam int DAT_W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bram_capture_writer_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) bus ();

    bram_capture_writer #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic             en;
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] din;
        logic             busy;
        logic             done;
        logic [ADR_W:0]   count;
    } out_t;

    typedef struct {
        logic             rst;
        logic             arm;
        logic             abort;
        logic             trig;
        logic [ADR_W-1:0] depth;
        logic             valid;
        logic [DAT_W-1:0] data;
        out_t             exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic a, input logic ab, input logic t,
                       input int dep, input logic v, input int dat,
                       input logic en, input int adr, input int din,
                       input logic busy, input logic done, input int cnt);
        vec_t x;
        x.rst       = r;
        x.arm       = a;
        x.abort     = ab;
        x.trig      = t;
        x.depth     = dep[ADR_W-1:0];
        x.valid     = v;
        x.data      = dat[DAT_W-1:0];
        x.exp.en    = en;
        x.exp.we    = en;
        x.exp.adr   = adr[ADR_W-1:0];
        x.exp.din   = din[DAT_W-1:0];
        x.exp.busy  = busy;
        x.exp.done  = done;
        x.exp.count = cnt[ADR_W:0];
        vecs.push_back(x);
    endtask

    task automatic drive(input logic r, input logic a, input logic ab, input logic t,
                         input logic [ADR_W-1:0] dep, input logic v, input logic [DAT_W-1:0] dat);
        rst           = r;
        bus.arm       = a;
        bus.abort     = ab;
        bus.trig      = t;
        bus.depth     = dep;
        bus.smp_valid = v;
        bus.smp_data  = dat;
    endtask

    task automatic check(input string name, input out_t exp);
        out_t act;
        act.en    = bus.bram_en;
        act.we    = bus.bram_we;
        act.adr   = bus.bram_adr;
        act.din   = bus.bram_din;
        act.busy  = bus.busy;
        act.done  = bus.done;
        act.count = bus.count;
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got en=%0b we=%0b adr=%0d din=%02h busy=%0b done=%0b count=%0d, want en=%0b we=%0b adr=%0d din=%02h busy=%0b done=%0b count=%0d",
                     name, act.en, act.we, act.adr, act.din, act.busy, act.done, act.count,
                     exp.en, exp.we, exp.adr, exp.din, exp.busy, exp.done, exp.count);
        end
    endtask

    initial begin
        out_t e;
        int   writes;

        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

        //   rst arm abt trg dep  val dat     en adr din   bsy dn cnt
        // depth=4 capture of 0x11..0x14
        add(1, 0, 0, 0, 0,   0, 'h00,    0, 0, 'h00, 0, 0, 0);
        add(0, 0, 0, 0, 0,   0, 'h00,    0, 0, 'h00, 0, 0, 0);
        add(0, 1, 0, 0, 4,   0, 'h00,    0, 0, 'h00, 1, 0, 0);
        add(0, 0, 0, 0, 4,   0, 'h00,    0, 0, 'h00, 1, 0, 0);
        add(0, 0, 0, 1, 4,   0, 'h00,    0, 0, 'h00, 1, 0, 0);
        add(0, 0, 0, 1, 4,   1, 'h11,    1, 0, 'h11, 1, 0, 1);
        add(0, 0, 0, 1, 1,   1, 'h12,    1, 1, 'h12, 1, 0, 2);
        add(0, 0, 0, 1, 1,   1, 'h13,    1, 2, 'h13, 1, 0, 3);
        add(0, 0, 0, 1, 1,   1, 'h14,    1, 3, 'h14, 1, 0, 4);
        add(0, 0, 0, 1, 1,   1, 'h15,    0, 3, 'h14, 0, 1, 4);
        add(0, 0, 0, 1, 1,   1, 'h16,    0, 3, 'h14, 0, 1, 4);
        // abort from DONE, then arm+abort together in IDLE
        add(0, 0, 1, 1, 1,   0, 'h00,    0, 3, 'h14, 0, 0, 4);
        add(0, 1, 1, 1, 2,   0, 'h00,    0, 3, 'h14, 0, 0, 4);
        // trig already high at arm: no capture until a fresh edge; arm in CAPTURE ignored
        add(0, 1, 0, 1, 2,   0, 'h00,    0, 3, 'h14, 1, 0, 0);
        add(0, 0, 0, 1, 2,   1, 'hAA,    0, 3, 'h14, 1, 0, 0);
        add(0, 0, 0, 1, 2,   1, 'hAB,    0, 3, 'h14, 1, 0, 0);
        add(0, 0, 0, 0, 2,   0, 'h00,    0, 3, 'h14, 1, 0, 0);
        add(0, 0, 0, 1, 2,   1, 'hAC,    0, 3, 'h14, 1, 0, 0);
        add(0, 0, 0, 1, 2,   1, 'hAD,    1, 0, 'hAD, 1, 0, 1);
        add(0, 1, 0, 1, 7,   1, 'hAE,    1, 1, 'hAE, 1, 0, 2);
        add(0, 0, 0, 1, 7,   1, 'hAF,    0, 1, 'hAE, 0, 1, 2);
        // depth=8, abort after 3 writes, then re-arm restarts at address 0
        add(0, 1, 0, 1, 8,   0, 'h00,    0, 1, 'hAE, 1, 0, 0);
        add(0, 0, 0, 0, 8,   0, 'h00,    0, 1, 'hAE, 1, 0, 0);
        add(0, 0, 0, 1, 8,   0, 'h00,    0, 1, 'hAE, 1, 0, 0);
        add(0, 0, 0, 1, 8,   1, 'h21,    1, 0, 'h21, 1, 0, 1);
        add(0, 0, 0, 1, 8,   1, 'h22,    1, 1, 'h22, 1, 0, 2);
        add(0, 0, 0, 1, 8,   1, 'h23,    1, 2, 'h23, 1, 0, 3);
        add(0, 0, 1, 1, 8,   1, 'h24,    0, 2, 'h23, 0, 0, 3);
        add(0, 0, 0, 1, 8,   1, 'h25,    0, 2, 'h23, 0, 0, 3);
        add(0, 1, 0, 1, 8,   0, 'h00,    0, 2, 'h23, 1, 0, 0);
        add(0, 0, 0, 0, 8,   0, 'h00,    0, 2, 'h23, 1, 0, 0);
        add(0, 0, 0, 1, 8,   0, 'h00,    0, 2, 'h23, 1, 0, 0);
        add(0, 0, 0, 1, 8,   1, 'h31,    1, 0, 'h31, 1, 0, 1);
        // reset the cycle after an accept: pending sample never written
        add(0, 0, 0, 1, 8,   1, 'h32,    1, 1, 'h32, 1, 0, 2);
        add(1, 0, 0, 1, 8,   1, 'h33,    0, 0, 'h00, 0, 0, 0);
        add(0, 0, 0, 1, 8,   1, 'h34,    0, 0, 'h00, 0, 0, 0);
        // reset beats arm
        add(1, 1, 0, 0, 8,   0, 'h00,    0, 0, 'h00, 0, 0, 0);
        add(0, 0, 0, 0, 8,   0, 'h00,    0, 0, 'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].arm, vecs[i].abort, vecs[i].trig,
                  vecs[i].depth, vecs[i].valid, vecs[i].data);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Full-buffer capture: depth=0 means 2048 samples; the 2049th is dropped.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        @(posedge clk);
        #1;
        e = '{en: 1'b0, we: 1'b0, adr: '0, din: '0, busy: 1'b1, done: 1'b0, count: '0};
        check("full_arm", e);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 11'd5, 1'b0, '0);
        @(posedge clk);
        #1;
        writes = 0;
        for (int i = 0; i <= 2048; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b0, 1'b0, 1'b1, 11'd5, 1'b1, i[DAT_W-1:0]);
            @(posedge clk);
            #1;
            if (bus.bram_en === 1'b1) writes++;
            if (i < 2048) begin
                e.en    = 1'b1;
                e.we    = 1'b1;
                e.adr   = i[ADR_W-1:0];
                e.din   = i[DAT_W-1:0];
                e.busy  = 1'b1;
                e.done  = 1'b0;
                e.count = (ADR_W+1)'(i + 1);
            end else begin
                e.en    = 1'b0;
                e.we    = 1'b0;
                e.adr   = 11'd2047;
                e.din   = 8'hFF;
                e.busy  = 1'b0;
                e.done  = 1'b1;
                e.count = 12'd2048;
            end
            check($sformatf("full_smp%0d", i), e);
        end
        n_vec++;
        if (writes != 2048) begin
            n_bad++;
            $display("FAIL full_write_total: got %0d writes, want 2048", writes);
        end

        // DONE holds with no writes until abort clears done.
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 11'd5, 1'b1, 8'h5A);
        @(posedge clk);
        #1;
        check("full_hold", e);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 11'd5, 1'b0, '0);
        @(posedge clk);
        #1;
        e.done = 1'b0;
        check("full_abort", e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_capture_writer.md
BRAM_CAPTURE_WRITER -- requirements
Module: bram_capture_writer

Interface
REQ-001 The block SHALL have parameter ADR_W, default 11, meaning the BRAM port-B address width.
REQ-002 The block SHALL have parameter DAT_W, default 8, meaning the sample and BRAM data width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1, the single rising-edge clock shared with the BRAM port-B clock.
REQ-005 The block SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-006 The block SHALL have port arm, input, 1, a one-cycle pulse from the EPP register side that starts a capture.
REQ-007 The block SHALL have port abort, input, 1, a one-cycle pulse that cancels a capture.
REQ-008 The block SHALL have port trig, input, 1, a level trigger whose rising edge starts sampling.
REQ-009 The block SHALL have port depth, input, ADR_W, the number of samples to capture, where 0 means 2^ADR_W.
REQ-010 The block SHALL have port smp_valid, input, 1, which qualifies smp_data.
REQ-011 The block SHALL have port smp_data, input, DAT_W, the sample value.
REQ-012 The block SHALL have port bram_adr, output, ADR_W, the port-B address.
REQ-013 The block SHALL have port bram_din, output, DAT_W, the port-B write data.
REQ-014 The block SHALL have port bram_en, output, 1, the port-B enable.
REQ-015 The block SHALL have port bram_we, output, 1, the port-B write enable.
REQ-016 The block SHALL have port busy, output, 1, which is high in the ARMED and CAPTURE states.
REQ-017 The block SHALL have port done, output, 1, a sticky flag meaning a capture has completed.
REQ-018 The block SHALL have port count, output, ADR_W+1, the number of samples written in the current or last capture.

Function
REQ-019 The state machine SHALL have exactly four states: IDLE, ARMED, CAPTURE and DONE.
REQ-020 In IDLE or DONE, an arm pulse SHALL move to ARMED on the next edge, clear done and count, and latch depth into an internal limit register.
REQ-021 The latched limit SHALL be the depth value, or 2^ADR_W when depth is 0; depth changes after the arm cycle SHALL have no effect.
REQ-022 trig SHALL be registered once; a rising edge SHALL be detected as trig high with the registered copy low.
REQ-023 In ARMED, a detected rising edge SHALL move to CAPTURE on the next edge.
REQ-024 A trig held high at arm time SHALL not start the capture; a fresh rising edge SHALL be required.
REQ-025 A sample SHALL be accepted only in CAPTURE with smp_valid high; the sample in the trigger-detection cycle SHALL not be accepted.
REQ-026 Each accepted sample SHALL produce a write one cycle later: bram_en=1, bram_we=1, bram_din equal to the accepted data, and bram_adr equal to the write pointer.
REQ-027 Each write SHALL last exactly one cycle, and the outputs SHALL be registered.
REQ-028 The write pointer SHALL start at 0 for every capture and increment by 1 after each write.
REQ-029 The write pointer SHALL wrap from 2^ADR_W-1 to 0, which occurs only when depth is 0.
REQ-030 count SHALL increment by 1 in the same cycle as each write.
REQ-031 After the write that makes count equal the limit, the state SHALL move to DONE and done SHALL go high on the following cycle.
REQ-032 No further writes SHALL occur after that write.
REQ-033 Back-to-back smp_valid SHALL be accepted at one sample per clock with no gaps or losses.
REQ-034 In DONE, done SHALL stay high and bram_we SHALL stay 0 until an arm or abort pulse.
REQ-035 When not writing, bram_en SHALL be 0, bram_we SHALL be 0, and bram_adr and bram_din SHALL hold their last values.
REQ-036 In ARMED or CAPTURE, arm SHALL be ignored.
REQ-037 An abort pulse in ARMED or CAPTURE SHALL move to IDLE on the next edge, leave done at 0, and keep count at the number of samples already written.
REQ-038 A write already pending from the previous cycle SHALL still complete when abort arrives.
REQ-039 When arm and abort are high in the same cycle, abort SHALL win.
REQ-040 In IDLE, abort SHALL have no effect.
REQ-041 busy SHALL be combinational from the state register.

Reset
REQ-042 While rst is high, the state SHALL be IDLE and all of the following SHALL be 0: bram_adr, bram_din, bram_en, bram_we, busy, done, count, the write pointer, the limit register and the trig register.
REQ-043 rst SHALL take priority over arm, abort and trig in the same cycle.
REQ-044 An rst asserted mid-capture SHALL suppress any pending write on the following cycle.

Verification
REQ-045 The bench SHALL check: depth=4, arm, trig rise, 4 consecutive samples 0x11..0x14 -> writes at adr 0..3 with those data, one cycle after each accept, done=1 one cycle after the 4th write, count=4.
REQ-046 The bench SHALL check: depth=0, 2049 valid samples -> exactly 2048 writes at adr 0..2047, count=2048, and the 2049th sample is not written.
REQ-047 The bench SHALL check: trig high before and during arm with no new edge -> busy=1, no writes; a later low-then-high on trig -> capture starts.
REQ-048 The bench SHALL check: depth=8, abort after 3 writes -> state IDLE, done=0, count=3, no further writes; a re-arm -> next write at adr 0.
REQ-049 The bench SHALL check: arm and abort in the same cycle from IDLE -> stays IDLE; arm during CAPTURE -> ignored and the capture completes normally.
REQ-050 The bench SHALL check: rst asserted the cycle after a sample accept -> no write issued, all outputs 0 on the next cycle.
